sprite_anim_seq: RTL and testbench



---
 rtl/sprite_anim_seq.sv | 211 +++++++++++++++++++++
 tb/tb_sprite_anim_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: sprite-animation frame sequencer with ROM address/pixel pipeline.
//   - Frame index advances on an internal tick (prescaler + dwell), in loop,
//     ping-pong, one-shot or freeze mode, and is applied only on vsync_pulse_i.
//   - Pixel path: rom_addr_o = frame_idx*FRAME_SIZE + pix_addr_i (registered),
//     pix_out_o/pix_valid_o return ROM_LAT+2 cycles after pix_req_i.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   en_i, restart_i           time-base enable, synchronous rewind
//   mode_i, frame_hold_i      animation mode, extra ticks per frame
//   vsync_pulse_i             display frame boundary strobe
//   pix_req_i, pix_addr_i     pixel request and in-frame address
//   rom_addr_o, rom_data_i    sprite ROM interface
//   pix_out_o, pix_valid_o    pixel colour and strobe to the mixer
//   frame_idx_o, frame_adv_o  displayed frame, one-cycle change pulse
//   done_o                    one-shot finished (sticky until restart)
module sprite_anim_seq #(
   parameter int PIX_AW     = 12,
   parameter int DATA_W     = 12,
   parameter int NUM_FRAMES = 4,
   parameter int FRAME_SIZE = 4096,
   parameter int TICK_DIV   = 6000000,
   parameter int HOLD_W     = 4,
   parameter int ROM_LAT    = 1,
   parameter logic [DATA_W-1:0] TRANSP = 12'h000,
   localparam int FI_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
   localparam int ROM_AW = PIX_AW + FI_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              restart_i,
   input  logic [1:0]        mode_i,
   input  logic [HOLD_W-1:0] frame_hold_i,
   input  logic              vsync_pulse_i,
   input  logic              pix_req_i,
   input  logic [PIX_AW-1:0] pix_addr_i,
   output logic [ROM_AW-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic [DATA_W-1:0] pix_out_o,
   output logic              pix_valid_o,
   output logic [FI_W-1:0]   frame_idx_o,
   output logic              frame_adv_o,
   output logic              done_o
);

   localparam int PR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PR_W-1:0]   PR_MAX = PR_W'(TICK_DIV - 1);
   localparam logic [FI_W-1:0]   LAST   = FI_W'(NUM_FRAMES - 1);
   localparam logic [ROM_AW-1:0] FS_RA  = ROM_AW'(FRAME_SIZE);
   localparam logic [PIX_AW:0]   FS_PA  = (PIX_AW + 1)'(FRAME_SIZE);

   localparam logic [1:0] MODE_LOOP = 2'd0;
   localparam logic [1:0] MODE_PP   = 2'd1;
   localparam logic [1:0] MODE_ONE  = 2'd2;
   localparam logic [1:0] MODE_FRZ  = 2'd3;
   localparam logic       DIR_UP    = 1'b0;
   localparam logic       DIR_DOWN  = 1'b1;

   logic [PR_W-1:0]   presc_q, presc_d;
   logic [HOLD_W-1:0] dwell_q, dwell_d;
   logic              pending_q, pending_d;
   logic              dir_q, dir_d;
   logic [FI_W-1:0]   idx_q, idx_d;
   logic              done_q, done_d;
   logic              adv_q, adv_d;
   logic              tick_s, set_pend_s, adv_s;
   logic [FI_W-1:0]   idx_nxt_s;
   logic              dir_nxt_s, done_nxt_s;

   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [ROM_LAT:0]  req_q;
   logic [ROM_LAT:0]  oor_q;
   logic              oor_s;
   logic [DATA_W-1:0] pix_out_q;
   logic              pix_valid_q;

   // Time base, dwell counter, pending flag and next-frame selection.
   always_comb begin
      tick_s     = en_i && (presc_q == PR_MAX);
      // ">=" also catches frame_hold being lowered below the running dwell.
      set_pend_s = tick_s && (dwell_q >= frame_hold_i);
      adv_s      = vsync_pulse_i && (pending_q || set_pend_s) && (mode_i != MODE_FRZ)
                   && !done_q && !restart_i;

      idx_nxt_s  = idx_q;
      dir_nxt_s  = dir_q;
      done_nxt_s = done_q;
      case (mode_i)
         MODE_LOOP: begin
            idx_nxt_s = (idx_q == LAST) ? '0 : idx_q + FI_W'(1);
         end
         MODE_PP: begin
            if (LAST == '0) begin
               idx_nxt_s = '0;
            end else if (((dir_q == DIR_UP) && (idx_q != LAST)) || (idx_q == '0)) begin
               idx_nxt_s = idx_q + FI_W'(1);
               dir_nxt_s = DIR_UP;
            end else begin
               idx_nxt_s = idx_q - FI_W'(1);
               dir_nxt_s = DIR_DOWN;
            end
         end
         MODE_ONE: begin
            // Saturate at the last frame, which is also where done is raised.
            if (idx_q == LAST) begin
               idx_nxt_s  = idx_q;
               done_nxt_s = 1'b1;
            end else begin
               idx_nxt_s  = idx_q + FI_W'(1);
               done_nxt_s = ((idx_q + FI_W'(1)) == LAST);
            end
         end
         default: begin
            idx_nxt_s = idx_q;
         end
      endcase

      if (restart_i) begin
         presc_d   = '0;
         dwell_d   = '0;
         pending_d = 1'b0;
         idx_d     = '0;
         dir_d     = DIR_UP;
         done_d    = 1'b0;
         adv_d     = 1'b0;
      end else begin
         if (!en_i) begin
            presc_d = presc_q;
         end else if (tick_s) begin
            presc_d = '0;
         end else begin
            presc_d = presc_q + PR_W'(1);
         end
         if (!tick_s) begin
            dwell_d = dwell_q;
         end else if (set_pend_s) begin
            dwell_d = '0;
         end else begin
            dwell_d = dwell_q + HOLD_W'(1);
         end
         pending_d = (pending_q || set_pend_s) && !adv_s;
         if (adv_s) begin
            idx_d  = idx_nxt_s;
            dir_d  = dir_nxt_s;
            done_d = done_nxt_s;
         end else begin
            idx_d  = idx_q;
            dir_d  = dir_q;
            done_d = done_q;
         end
         adv_d = adv_s && (idx_nxt_s != idx_q);
      end
   end

   // Animation control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         dwell_q   <= '0;
         pending_q <= 1'b0;
         dir_q     <= DIR_UP;
         idx_q     <= '0;
         done_q    <= 1'b0;
         adv_q     <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         dwell_q   <= dwell_d;
         pending_q <= pending_d;
         dir_q     <= dir_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         adv_q     <= adv_d;
      end
   end

   // ROM address and range flag; frame index is the one held this cycle.
   always_comb begin
      rom_addr_d = ROM_AW'(idx_q) * FS_RA + ROM_AW'(pix_addr_i);
      oor_s      = ({1'b0, pix_addr_i} >= FS_PA);
   end

   // Pixel pipeline: req/oor travel alongside the ROM read, output on last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q  <= '0;
         req_q       <= '0;
         oor_q       <= '0;
         pix_out_q   <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         req_q      <= {req_q[ROM_LAT-1:0], pix_req_i};
         oor_q      <= {oor_q[ROM_LAT-1:0], oor_s};
         if (req_q[ROM_LAT]) begin
            pix_out_q   <= oor_q[ROM_LAT] ? TRANSP : rom_data_i;
            pix_valid_q <= 1'b1;
         end else begin
            pix_out_q   <= pix_out_q;
            pix_valid_q <= 1'b0;
         end
      end
   end

   assign rom_addr_o  = rom_addr_q;
   assign pix_out_o   = pix_out_q;
   assign pix_valid_o = pix_valid_q;
   assign frame_idx_o = idx_q;
   assign frame_adv_o = adv_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq: a vector table for the mode sequences,
// then hand-written sequences for dwell timing, freeze/resume, pixel path and
// asynchronous reset. Three instances share inputs: the 4-frame reference, a
// 1-frame variant and a FRAME_SIZE=3000 variant.
module tb_sprite_anim_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, restart, vsync, pix_req;
   logic [1:0]  mode;
   logic [3:0]  hold;
   logic [11:0] pix_addr;

   logic [13:0] rom_addr0, rom_addr2;
   logic [12:0] rom_addr1;
   logic [11:0] rom_data0, rom_data2;
   logic [11:0] rom_data1;
   logic [11:0] pix_out0, pix_out1, pix_out2;
   logic        pix_valid0, pix_valid1, pix_valid2;
   logic [1:0]  idx0, idx2;
   logic [0:0]  idx1;
   logic        adv0, adv1, adv2, done0, done1, done2;

   assign rom_data1 = 12'h000;

   sprite_anim_seq #(.NUM_FRAMES(4), .FRAME_SIZE(4096), .TICK_DIV(4), .ROM_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .restart_i(restart), .mode_i(mode),
      .frame_hold_i(hold), .vsync_pulse_i(vsync), .pix_req_i(pix_req), .pix_addr_i(pix_addr),
      .rom_addr_o(rom_addr0), .rom_data_i(rom_data0), .pix_out_o(pix_out0),
      .pix_valid_o(pix_valid0), .frame_idx_o(idx0), .frame_adv_o(adv0), .done_o(done0));

   sprite_anim_seq #(.NUM_FRAMES(1), .FRAME_SIZE(4096), .TICK_DIV(4), .ROM_LAT(1)) dut_nf1 (
      .clk(clk), .rst_n(rst_n), .en_i(en), .restart_i(restart), .mode_i(mode),
      .frame_hold_i(hold), .vsync_pulse_i(vsync), .pix_req_i(pix_req), .pix_addr_i(pix_addr),
      .rom_addr_o(rom_addr1), .rom_data_i(rom_data1), .pix_out_o(pix_out1),
      .pix_valid_o(pix_valid1), .frame_idx_o(idx1), .frame_adv_o(adv1), .done_o(done1));

   sprite_anim_seq #(.NUM_FRAMES(4), .FRAME_SIZE(3000), .TICK_DIV(4), .ROM_LAT(1)) dut_fs3k (
      .clk(clk), .rst_n(rst_n), .en_i(en), .restart_i(restart), .mode_i(mode),
      .frame_hold_i(hold), .vsync_pulse_i(vsync), .pix_req_i(pix_req), .pix_addr_i(pix_addr),
      .rom_addr_o(rom_addr2), .rom_data_i(rom_data2), .pix_out_o(pix_out2),
      .pix_valid_o(pix_valid2), .frame_idx_o(idx2), .frame_adv_o(adv2), .done_o(done2));

   // ROM content: low address bits xor'ed with the frame bits moved to the top.
   function automatic logic [11:0] rom_fn(input logic [13:0] a);
      return a[11:0] ^ {a[13:12], 10'd0};
   endfunction

   // One-cycle-latency ROM models.
   always @(posedge clk) begin
      rom_data0 <= rom_fn(rom_addr0);
      rom_data2 <= rom_fn(rom_addr2);
   end

   // Sticky record of any frame_adv from the 1-frame instance.
   logic nf1_adv_seen;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) nf1_adv_seen <= 1'b0;
      else if (adv1) nf1_adv_seen <= 1'b1;
   end

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       is_rst;
      logic [1:0] mode;
      int         wait_cyc;
      logic [1:0] e_idx;
      logic       e_adv;
      logic       e_done;
   } vec_t;

   vec_t tbl[29];
   int   n;

   initial begin
      tbl[0]  = '{1'b1, 2'd0, 0,  2'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 2'd0, 20, 2'd1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 2'd0, 20, 2'd2, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 2'd0, 20, 2'd3, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 2'd0, 20, 2'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 2'd1, 0,  2'd0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 2'd1, 20, 2'd1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 2'd1, 20, 2'd2, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 2'd1, 20, 2'd3, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 2'd1, 20, 2'd2, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 2'd1, 20, 2'd1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 2'd1, 20, 2'd0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 2'd1, 20, 2'd1, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 2'd1, 20, 2'd2, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 2'd1, 20, 2'd3, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 2'd1, 20, 2'd2, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 2'd2, 0,  2'd0, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 2'd2, 20, 2'd1, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 2'd2, 20, 2'd2, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 2'd1, 20, 2'd3, 1'b1, 1'b0};
      tbl[20] = '{1'b1, 2'd2, 0,  2'd0, 1'b0, 1'b0};
      tbl[21] = '{1'b0, 2'd2, 20, 2'd1, 1'b1, 1'b0};
      tbl[22] = '{1'b0, 2'd2, 20, 2'd2, 1'b1, 1'b0};
      tbl[23] = '{1'b0, 2'd2, 20, 2'd3, 1'b1, 1'b1};
      tbl[24] = '{1'b0, 2'd2, 20, 2'd3, 1'b0, 1'b1};
      tbl[25] = '{1'b0, 2'd0, 20, 2'd3, 1'b0, 1'b1};
      tbl[26] = '{1'b1, 2'd3, 0,  2'd0, 1'b0, 1'b0};
      tbl[27] = '{1'b0, 2'd3, 20, 2'd0, 1'b0, 1'b0};
      tbl[28] = '{1'b0, 2'd0, 1,  2'd1, 1'b1, 1'b0};

      rst_n = 1'b0; en = 1'b0; restart = 1'b0; vsync = 1'b0; pix_req = 1'b0;
      mode = 2'd0; hold = 4'd1; pix_addr = 12'h000;
      #12;
      chk("rst_idx", idx0, 0);
      chk("rst_adv", adv0, 0);
      chk("rst_done", done0, 0);
      chk("rst_valid", pix_valid0, 0);
      chk("rst_pix", pix_out0, 0);
      chk("rst_romaddr", rom_addr0, 0);
      #11 rst_n = 1'b1;
      en = 1'b1;
      clk1();

      // Mode sequences, hold=1: a pending advance is always ready after 20 cycles.
      for (int i = 0; i < 29; i++) begin
         mode = tbl[i].mode;
         if (tbl[i].is_rst) begin
            restart = 1'b1;
            clk1();
            restart = 1'b0;
         end else begin
            repeat (tbl[i].wait_cyc) clk1();
            vsync = 1'b1;
            clk1();
            vsync = 1'b0;
         end
         chk($sformatf("v%0d_idx", i), idx0, tbl[i].e_idx);
         chk($sformatf("v%0d_adv", i), adv0, tbl[i].e_adv);
         chk($sformatf("v%0d_done", i), done0, tbl[i].e_done);
         clk1();
         chk($sformatf("v%0d_adv_fall", i), adv0, 0);
      end
      chk("nf1_idx", idx1, 0);
      chk("nf1_no_adv", nf1_adv_seen, 0);

      // Many ticks without vsync, then two vsyncs: exactly one advance.
      hold = 4'd0; mode = 2'd0;
      restart = 1'b1; clk1(); restart = 1'b0;
      repeat (40) clk1();
      vsync = 1'b1; clk1(); vsync = 1'b0;
      chk("multi_tick_idx", idx0, 1);
      chk("multi_tick_adv", adv0, 1);
      en = 1'b0; clk1();
      vsync = 1'b1; clk1(); vsync = 1'b0;
      chk("single_adv_idx", idx0, 1);
      chk("single_adv_adv", adv0, 0);

      // en=0 mid-dwell freezes prescaler and dwell; resume continues the count.
      hold = 4'd2; en = 1'b1;
      restart = 1'b1; clk1(); restart = 1'b0;
      repeat (5) clk1();
      en = 1'b0; vsync = 1'b1;
      repeat (3) clk1();
      chk("frozen_idx", idx0, 0);
      chk("frozen_adv", adv0, 0);
      vsync = 1'b0;
      repeat (17) clk1();
      en = 1'b1; vsync = 1'b1;
      n = 0;
      do begin clk1(); n++; end while (adv0 !== 1'b1 && n < 40);
      vsync = 1'b0;
      chk("resume_cycles", n, 7);
      chk("resume_idx", idx0, 1);
      repeat (15) clk1();
      vsync = 1'b1; clk1(); vsync = 1'b0;
      chk("to_frame2_idx", idx0, 2);
      chk("fs3k_idx", idx2, 2);
      en = 1'b0; clk1();

      // Pixel path, frame 2: back-to-back requests, one out of range for FS=3000.
      pix_req = 1'b1; pix_addr = 12'h010;
      clk1();
      chk("romaddr_f2", rom_addr0, 14'h2010);
      chk("romaddr_fs3k", rom_addr2, 14'h1780);
      chk("valid_lat1", pix_valid0, 0);
      pix_addr = 12'hBB8;
      clk1();
      chk("valid_lat2", pix_valid0, 0);
      pix_addr = 12'hBB7;
      clk1();
      chk("valid_lat3", pix_valid0, 1);
      chk("pix_f2", pix_out0, 12'h810);
      chk("pix_fs3k", pix_out2, 12'h380);
      pix_req = 1'b0;
      clk1();
      chk("pix_bb8", pix_out0, 12'h3B8);
      chk("pix_transp", pix_out2, 12'h000);
      chk("valid_transp", pix_valid2, 1);
      clk1();
      chk("pix_bb7", pix_out0, 12'h3B7);
      chk("pix_fs3k_last", pix_out2, 12'hB27);
      clk1();
      chk("valid_drop", pix_valid0, 0);
      chk("pix_hold", pix_out0, 12'h3B7);

      // Asynchronous reset mid-pipeline and mid-dwell.
      en = 1'b1; pix_req = 1'b1; pix_addr = 12'h020;
      clk1();
      pix_req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_idx", idx0, 0);
      chk("arst_romaddr", rom_addr0, 0);
      chk("arst_pix", pix_out0, 0);
      chk("arst_valid", pix_valid0, 0);
      chk("arst_done", done0, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      hold = 4'd2; mode = 2'd0; vsync = 1'b1;
      n = 0;
      do begin clk1(); n++; end while (adv0 !== 1'b1 && n < 40);
      vsync = 1'b0;
      chk("post_rst_cycles", n, 12);
      chk("post_rst_idx", idx0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
